// File: rtl/hash_msg_feeder_if.sv
// Byte-feeder bundle: host job control, upstream byte stream, hash-core
// byte interface and digest/result handshake.
interface hash_msg_feeder_if #(
  parameter int LEN_W    = 64,
  parameter int DIGEST_W = 32
);
  // host job control
  logic                start;
  logic [LEN_W-1:0]    msg_len;
  logic                busy;
  // upstream byte source
  logic [7:0]          s_byte;
  logic                s_valid;
  logic                s_ready;
  // hash core byte side
  logic [7:0]          M;
  logic                M_valid;
  logic [LEN_W-1:0]    input_length;
  logic                hash_ready;
  logic [DIGEST_W-1:0] digest;
  // result handshake
  logic [DIGEST_W-1:0] result;
  logic                result_valid;
  logic                result_ack;
  logic                timeout_err;

  // feeder side
  modport master (
    input  start, msg_len, s_byte, s_valid, hash_ready, digest, result_ack,
    output busy, s_ready, M, M_valid, input_length, result, result_valid, timeout_err
  );

  // environment side (host, upstream source, hash core)
  modport slave (
    output start, msg_len, s_byte, s_valid, hash_ready, digest, result_ack,
    input  busy, s_ready, M, M_valid, input_length, result, result_valid, timeout_err
  );
endinterface

// File: rtl/hash_msg_feeder.sv
// hash_msg_feeder: pulls a message byte stream from an upstream valid/ready
// source, strobes it into the hash core one byte at a time with an idle gap
// after each pulse, then waits (with a timeout) for the digest and hands it
// to the host on a valid/ack handshake.
module hash_msg_feeder #(
  parameter int LEN_W      = 64,
  parameter int DIGEST_W   = 32,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  hash_msg_feeder_if.master bus
);

  localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_GAP   = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          m_q, m_d;
  logic                m_valid_q, m_valid_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [DIGEST_W-1:0] result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic                timeout_err_q, timeout_err_d;

  // Next-state and next-output decode; strobe and counters default to idle
  always_comb begin
    state_d        = state_q;
    m_d            = m_q;
    m_valid_d      = 1'b0;
    len_d          = len_q;
    rem_d          = rem_q;
    gap_d          = '0;
    to_d           = '0;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    timeout_err_d  = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d = bus.msg_len;
          rem_d = bus.msg_len;
          if (bus.msg_len == '0) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FETCH: begin
        if (bus.s_valid) begin
          m_d       = bus.s_byte;
          m_valid_d = 1'b1;
          // never wraps below zero
          rem_d     = (rem_q != '0) ? (rem_q - LEN_W'(1)) : rem_q;
          state_d   = S_SEND;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_SEND: begin
        if (GAP_CYCLES != 0) begin
          state_d = S_GAP;
        end else if (rem_q == '0) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (rem_q == '0) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      S_WAIT: begin
        // digest arrival takes priority over an expiring timeout
        if (bus.hash_ready) begin
          result_d       = bus.digest;
          result_valid_d = 1'b1;
          state_d        = S_DONE;
        end else if (to_q == TO_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_ERR;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      S_DONE: begin
        if (bus.result_ack) begin
          result_valid_d = 1'b0;
          state_d        = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end

      S_ERR: begin
        if (bus.result_ack) begin
          timeout_err_d = 1'b0;
          state_d       = S_IDLE;
        end else begin
          state_d = S_ERR;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      m_q            <= 8'h00;
      m_valid_q      <= 1'b0;
      len_q          <= '0;
      rem_q          <= '0;
      gap_q          <= '0;
      to_q           <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      m_q            <= m_d;
      m_valid_q      <= m_valid_d;
      len_q          <= len_d;
      rem_q          <= rem_d;
      gap_q          <= gap_d;
      to_q           <= to_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign bus.M            = m_q;
  assign bus.M_valid      = m_valid_q;
  assign bus.input_length = len_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.s_ready      = (state_q == S_FETCH);

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Directed bench for hash_msg_feeder (GAP_CYCLES=1, TIMEOUT=16).
module tb_hash_msg_feeder;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  hash_msg_feeder_if #(.LEN_W(64), .DIGEST_W(32)) bus ();

  hash_msg_feeder #(
    .LEN_W(64), .DIGEST_W(32), .GAP_CYCLES(1), .TIMEOUT(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // byte-strobe monitor
  int         cyc;
  int         mv_high;
  int         mv_rises;
  int         last_rise;
  int         min_spacing;
  logic       mv_prev;
  logic [7:0] byte_q[$];

  initial begin
    cyc = 0; mv_high = 0; mv_rises = 0; last_rise = -1;
    min_spacing = 1000; mv_prev = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.M_valid === 1'b1) begin
      mv_high <= mv_high + 1;
      if (!mv_prev) begin
        mv_rises <= mv_rises + 1;
        byte_q.push_back(bus.M);
        if (last_rise >= 0 && (cyc - last_rise) < min_spacing)
          min_spacing <= cyc - last_rise;
        last_rise <= cyc;
      end
    end
    mv_prev <= bus.M_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [63:0] len);
    bus.start   = 1'b1;
    bus.msg_len = len;
    tick();
    bus.start   = 1'b0;
  endtask

  // offer one byte (after an optional stall) and return in the SEND cycle
  task automatic send_byte(input logic [7:0] b, input int stall);
    int n;
    bus.s_valid = 1'b0;
    repeat (stall) tick();
    bus.s_valid = 1'b1;
    bus.s_byte  = b;
    n = 0;
    while (bus.s_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("s_ready_seen", 64'(n < 50), 64'd1);
    tick();
    bus.s_valid = 1'b0;
    chk("m_valid_pulse", 64'(bus.M_valid), 64'd1);
    chk("m_byte", 64'(bus.M), 64'(b));
  endtask

  task automatic core_digest(input logic [31:0] d, input int delay);
    repeat (delay) tick();
    bus.hash_ready = 1'b1;
    bus.digest     = d;
    tick();
    bus.hash_ready = 1'b0;
  endtask

  task automatic ack();
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
  endtask

  int r0;
  int n;

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.msg_len = 64'd0; bus.s_byte = 8'h00; bus.s_valid = 1'b0;
    bus.hash_ready = 1'b0; bus.digest = 32'h0; bus.result_ack = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // reset state
    chk("rst_M", 64'(bus.M), 64'h0);
    chk("rst_M_valid", 64'(bus.M_valid), 64'd0);
    chk("rst_input_length", bus.input_length, 64'd0);
    chk("rst_result", 64'(bus.result), 64'h0);
    chk("rst_result_valid", 64'(bus.result_valid), 64'd0);
    chk("rst_timeout_err", 64'(bus.timeout_err), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);

    // 1: empty message
    r0 = mv_rises;
    start_job(64'd0);
    chk("t1_busy", 64'(bus.busy), 64'd1);
    chk("t1_s_ready", 64'(bus.s_ready), 64'd0);
    chk("t1_input_length", bus.input_length, 64'd0);
    core_digest(32'hDEADBEEF, 4);
    chk("t1_result_valid", 64'(bus.result_valid), 64'd1);
    chk("t1_result", 64'(bus.result), 64'hDEADBEEF);
    tick(); tick();
    chk("t1_result_valid_held", 64'(bus.result_valid), 64'd1);
    ack();
    chk("t1_result_valid_clr", 64'(bus.result_valid), 64'd0);
    chk("t1_busy_clr", 64'(bus.busy), 64'd0);
    chk("t1_result_hold", 64'(bus.result), 64'hDEADBEEF);
    chk("t1_no_pulses", 64'(mv_rises - r0), 64'd0);

    // 2: single char
    r0 = mv_rises;
    byte_q.delete();
    start_job(64'd1);
    chk("t2_input_length", bus.input_length, 64'd1);
    send_byte(8'h41, 0);
    tick();
    chk("t2_m_valid_drop", 64'(bus.M_valid), 64'd0);
    chk("t2_m_hold", 64'(bus.M), 64'h41);
    tick();
    chk("t2_input_length_held", bus.input_length, 64'd1);
    core_digest(32'h12345678, 1);
    chk("t2_result", 64'(bus.result), 64'h12345678);
    chk("t2_result_valid", 64'(bus.result_valid), 64'd1);
    ack();
    chk("t2_pulses", 64'(mv_rises - r0), 64'd1);

    // 3: "abc" with upstream stalls
    r0 = mv_rises;
    byte_q.delete();
    start_job(64'd3);
    send_byte(8'h61, 0);
    chk("t3_s_ready_send", 64'(bus.s_ready), 64'd0);
    tick();
    chk("t3_s_ready_gap", 64'(bus.s_ready), 64'd0);
    tick();
    chk("t3_s_ready_fetch", 64'(bus.s_ready), 64'd1);
    send_byte(8'h62, 2);
    send_byte(8'h63, 3);
    tick(); tick();
    chk("t3_s_ready_wait", 64'(bus.s_ready), 64'd0);
    chk("t3_pulses", 64'(mv_rises - r0), 64'd3);
    chk("t3_qsize", 64'(byte_q.size()), 64'd3);
    if (byte_q.size() == 3) begin
      chk("t3_b0", 64'(byte_q[0]), 64'h61);
      chk("t3_b1", 64'(byte_q[1]), 64'h62);
      chk("t3_b2", 64'(byte_q[2]), 64'h63);
    end
    core_digest(32'hA9993E36, 0);
    chk("t3_result", 64'(bus.result), 64'hA9993E36);
    ack();

    // 4: timeout
    start_job(64'd2);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    tick(); tick();
    n = 0;
    while (bus.timeout_err !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("t4_wait_cycles", 64'(n), 64'd16);
    chk("t4_timeout_err", 64'(bus.timeout_err), 64'd1);
    chk("t4_result_valid", 64'(bus.result_valid), 64'd0);
    tick();
    chk("t4_err_held", 64'(bus.timeout_err), 64'd1);
    ack();
    chk("t4_err_clr", 64'(bus.timeout_err), 64'd0);
    chk("t4_busy_clr", 64'(bus.busy), 64'd0);

    // 5: reset mid-job, then a fresh job
    r0 = mv_rises;
    start_job(64'd5);
    send_byte(8'hA1, 0);
    send_byte(8'hA2, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_m_valid", 64'(bus.M_valid), 64'd0);
    chk("t5_busy", 64'(bus.busy), 64'd0);
    chk("t5_s_ready", 64'(bus.s_ready), 64'd0);
    chk("t5_input_length", bus.input_length, 64'd0);
    chk("t5_M", 64'(bus.M), 64'h0);
    tick(); tick();
    chk("t5_pulses_abandoned", 64'(mv_rises - r0), 64'd2);
    start_job(64'd1);
    send_byte(8'h5A, 0);
    tick(); tick();
    core_digest(32'hCAFEF00D, 0);
    chk("t5_result", 64'(bus.result), 64'hCAFEF00D);
    ack();
    chk("t5_busy_clr", 64'(bus.busy), 64'd0);

    // 6: start during SEND and hash_ready during GAP are ignored
    r0 = mv_rises;
    byte_q.delete();
    start_job(64'd3);
    send_byte(8'h11, 0);
    bus.start = 1'b1; bus.msg_len = 64'd9;
    tick();
    bus.start = 1'b0;
    bus.hash_ready = 1'b1; bus.digest = 32'hBAD0BAD0;
    tick();
    bus.hash_ready = 1'b0;
    chk("t6_input_length", bus.input_length, 64'd3);
    chk("t6_no_capture", 64'(bus.result_valid), 64'd0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    tick(); tick();
    chk("t6_result_valid_pre", 64'(bus.result_valid), 64'd0);
    core_digest(32'h0F0F1234, 1);
    chk("t6_result", 64'(bus.result), 64'h0F0F1234);
    chk("t6_pulses", 64'(mv_rises - r0), 64'd3);
    chk("t6_qsize", 64'(byte_q.size()), 64'd3);
    if (byte_q.size() == 3) begin
      chk("t6_b0", 64'(byte_q[0]), 64'h11);
      chk("t6_b1", 64'(byte_q[1]), 64'h22);
      chk("t6_b2", 64'(byte_q[2]), 64'h33);
    end
    ack();

    // pulse shape over the whole run
    chk("pulse_width", 64'(mv_high), 64'(mv_rises));
    chk("total_pulses", 64'(mv_rises), 64'd12);
    chk("min_spacing", 64'(min_spacing), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hash_msg_feeder.md
Name: hash_msg_feeder

Overview:
- Initiator side of the lightHashDES byte interface. Takes a message length and a byte stream from an upstream valid/ready source.
- Drives M/M_valid/input_length into the hash core one byte at a time, with a guaranteed idle gap between bytes.
- Waits for hash_ready, captures the digest, and presents it to the host on a valid/ack handshake with timeout protection.
- Sits between host/UART-side buffering and lightHashDES.

Parameters:
LEN_W, 64, width of message length / input_length
DIGEST_W, 32, digest width
GAP_CYCLES, 1, M_valid-low cycles inserted after each byte pulse (0 allowed)
TIMEOUT, 4096, max cycles in WAIT_HASH before error

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  job start pulse, honoured only in IDLE
msg_len  in  LEN_W  byte count, sampled on accepted start
busy  out  1  high in every state except IDLE
s_byte  in  8  upstream message byte
s_valid  in  1  upstream byte valid
s_ready  out  1  feeder accepts byte (high only in FETCH)
M  out  8  byte to hash core
M_valid  out  1  single-cycle byte strobe to hash core
input_length  out  LEN_W  message length to hash core, held for whole job
hash_ready  in  1  core digest-valid
digest  in  DIGEST_W  core digest
result  out  DIGEST_W  captured digest
result_valid  out  1  result available
result_ack  in  1  host consumes result/error
timeout_err  out  1  hash_ready not seen within TIMEOUT

Behaviour:
- One clock (clk). rst_n is synchronous and active-low, sampled on the rising edge. All outputs are registered, except s_ready and busy, which decode directly from state.
- Reset values:
  - State IDLE.
  - M=0, M_valid=0, input_length=0.
  - result=0, result_valid=0, timeout_err=0.
  - Remaining and gap counters 0.
- Reset mid-job: the next edge returns to IDLE with the reset values above. No further M_valid pulses. Partially sent bytes are abandoned.
- States and transitions:
  - IDLE: on start=1, latch msg_len into input_length and into the remaining counter. If msg_len==0 go WAIT_HASH (no byte pulses); else go FETCH. start outside IDLE is ignored.
  - FETCH: s_ready=1. On s_valid&s_ready: next edge M<=s_byte, M_valid<=1, remaining decrements, go SEND. Stalls indefinitely while s_valid=0.
  - SEND: M_valid is high for exactly this one cycle and drops at the next edge. M holds its value until the next byte.
    - If GAP_CYCLES>0, go GAP.
    - Else, if remaining==0 go WAIT_HASH; otherwise go FETCH.
  - GAP: count GAP_CYCLES cycles with M_valid=0, then go WAIT_HASH if remaining==0, else FETCH.
  - WAIT_HASH: timeout counter increments each cycle.
    - On hash_ready=1: result<=digest, result_valid<=1, go DONE.
    - If the counter reaches TIMEOUT-1 without hash_ready: timeout_err<=1, go ERR.
    - hash_ready and timeout on the same cycle: hash_ready wins.
  - DONE: result_valid held. On result_ack: result_valid<=0, go IDLE. result holds its value until the next capture.
  - ERR: timeout_err held. On result_ack: timeout_err<=0, go IDLE.
- hash_ready is ignored outside WAIT_HASH; a spurious assertion during FETCH/SEND/GAP has no effect.
- input_length is constant from the cycle after start until the next accepted start.
- Byte pulse spacing: minimum 1+GAP_CYCLES cycles between M_valid rising edges. Plus 1 FETCH cycle per byte when s_valid is already high.
- Byte order on M equals upstream acceptance order. Exactly msg_len pulses per job.
- Length arithmetic is unsigned LEN_W, with no wrap: remaining decrements only on accepted bytes and never below 0.

Test Plan:
1. Empty message: start, msg_len=0; core model asserts hash_ready with digest=0xDEADBEEF 5 cycles later -> zero M_valid pulses, input_length=0, result=0xDEADBEEF, result_valid high until result_ack, then busy=0.
2. Single char: msg_len=1, s_byte=0x41 valid -> exactly one 1-cycle M_valid with M=0x41, input_length=1 held; digest 0x12345678 captured into result.
3. "abc" with upstream stalls (s_valid low 3 cycles between bytes), GAP_CYCLES=1 -> M sequence 0x61, 0x62, 0x63, each pulse 1 cycle, ≥2 cycles apart; s_ready high only in FETCH.
4. Timeout: msg_len=2, hash_ready never asserted, TIMEOUT=16 -> timeout_err=1 after 16 WAIT_HASH cycles, result_valid=0; result_ack clears timeout_err and returns to IDLE.
5. Reset mid-job: msg_len=5, rst_n low after 2 bytes sent -> next edge M_valid=0, busy=0, s_ready=0, input_length=0; a fresh start with msg_len=1 then completes normally.
6. Protocol abuse: start pulsed during SEND, and hash_ready pulsed during GAP -> both ignored; the job still emits all msg_len bytes and captures only the digest presented during WAIT_HASH.
